// File: rtl/nios_core_pio_pkg.sv
// -----------------------------------------------------------------------------
// nios_core_pio_pkg
// Shared constants for the Nios output PIO (LED driver).
//   ADDR_*         word addresses of the Avalon-MM register map
//   RDATA_DEFAULT  value returned for unmapped / disabled addresses
// -----------------------------------------------------------------------------
package nios_core_pio_pkg;

  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_BLINK_MASK   = 3'd1;
  localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_STATUS       = 3'd3;
  localparam logic [2:0] ADDR_OUTSET       = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR     = 3'd5;

  localparam logic [31:0] RDATA_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/nios_core_pio_blink_timer.sv
// -----------------------------------------------------------------------------
// nios_core_pio_blink_timer
// Blink engine: a prescaler producing one tick every PRESCALE clocks, and a
// period counter that toggles phase every `period` ticks.
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset
//   period   in   half-period in ticks; 0 stops the engine with phase=0
//   restart  in   one-cycle pulse clearing all counters and phase
//   phase    out  current blink phase (1 = masked LEDs off)
// -----------------------------------------------------------------------------
module nios_core_pio_blink_timer #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                restart,
  output logic                phase
);

  // A prescaler of 1 still needs a 1-bit counter that never leaves 0.
  localparam int unsigned     PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
  logic                phase_q,   phase_d;
  logic                tick_s;

  // Next-state for prescaler, period counter and phase.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    per_cnt_d = per_cnt_q;
    phase_d   = phase_q;
    tick_s    = (pre_cnt_q == PRE_LAST);
    // restart also covers a period lowered below per_cnt: no wrap-around.
    if (restart || (period == {PERIOD_W{1'b0}})) begin
      pre_cnt_d = {PRE_W{1'b0}};
      per_cnt_d = {PERIOD_W{1'b0}};
      phase_d   = 1'b0;
    end else if (tick_s) begin
      pre_cnt_d = {PRE_W{1'b0}};
      if (per_cnt_q == (period - {{(PERIOD_W-1){1'b0}}, 1'b1})) begin
        per_cnt_d = {PERIOD_W{1'b0}};
        phase_d   = ~phase_q;
      end else begin
        per_cnt_d = per_cnt_q + {{(PERIOD_W-1){1'b0}}, 1'b1};
      end
    end else begin
      pre_cnt_d = pre_cnt_q + {{(PRE_W-1){1'b0}}, 1'b1};
    end
  end

  // Timer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_cnt_q <= {PRE_W{1'b0}};
      per_cnt_q <= {PERIOD_W{1'b0}};
      phase_q   <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      per_cnt_q <= per_cnt_d;
      phase_q   <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/nios_core_pio_led_out.sv
// -----------------------------------------------------------------------------
// nios_core_pio_led_out
// Avalon-MM slave output PIO driving WIDTH LEDs, with atomic set/clear and an
// optional hardware blink engine.
// Build option: define NIOS_CORE_PIO_LED_BLINK_EN to include the blink engine
// (BLINK_MASK, BLINK_PERIOD, STATUS registers). Without it addresses 1-3 read
// 0 and out_port follows DATA directly.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   address[2:0]          word address (0 DATA,1 MASK,2 PERIOD,3 STATUS,
//                         4 OUTSET,5 OUTCLEAR)
//   chipselect, write_n   write strobe = chipselect & ~write_n
//   writedata[31:0]       write data
//   readdata[31:0]        registered read data, mux(address) every cycle
//   out_port[WIDTH-1:0]   LED drive
// -----------------------------------------------------------------------------
module nios_core_pio_led_out
  import nios_core_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned PERIOD_W    = 16,
  parameter int unsigned PRESCALE    = 50000,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr_s;
  logic [WIDTH-1:0] wd_s;
  logic [WIDTH-1:0] data_q, data_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [31:0]      data_ext_s;
  logic             phase_s;
  logic             unused_s;

  assign wr_s     = chipselect & ~write_n;
  assign wd_s     = writedata[WIDTH-1:0];
  assign unused_s = ^writedata;

`ifdef NIOS_CORE_PIO_LED_BLINK_EN
  logic [WIDTH-1:0]    mask_q,   mask_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [31:0]         mask_ext_s;
  logic [31:0]         period_ext_s;
  logic                period_wr_s;

  assign period_wr_s = wr_s & (address == ADDR_BLINK_PERIOD);

  // Next value of the blink mask and period registers.
  always_comb begin
    mask_d   = mask_q;
    period_d = period_q;
    if (wr_s) begin
      case (address)
        ADDR_BLINK_MASK:   mask_d   = wd_s;
        ADDR_BLINK_PERIOD: period_d = writedata[PERIOD_W-1:0];
        default: begin
          mask_d   = mask_q;
          period_d = period_q;
        end
      endcase
    end else begin
      mask_d   = mask_q;
      period_d = period_q;
    end
  end

  // Blink configuration registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_q   <= {WIDTH{1'b0}};
      period_q <= {PERIOD_W{1'b0}};
    end else begin
      mask_q   <= mask_d;
      period_q <= period_d;
    end
  end

  // Zero-extend blink registers onto the 32-bit read bus.
  always_comb begin
    mask_ext_s                 = {32{1'b0}};
    mask_ext_s[WIDTH-1:0]      = mask_q;
    period_ext_s               = {32{1'b0}};
    period_ext_s[PERIOD_W-1:0] = period_q;
  end

  nios_core_pio_blink_timer #(
    .PRESCALE (PRESCALE),
    .PERIOD_W (PERIOD_W)
  ) u_blink_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period_q),
    .restart (period_wr_s),
    .phase   (phase_s)
  );

  assign out_port = data_q & ~(mask_q & {WIDTH{phase_s}});
`else
  logic [31:0] unused_cfg_s;

  assign phase_s      = 1'b0;
  assign unused_cfg_s = 32'(PERIOD_W) ^ 32'(PRESCALE);
  assign out_port     = data_q;
`endif

  // Next value of DATA: plain write, atomic set, atomic clear.
  always_comb begin
    data_d = data_q;
    if (wr_s) begin
      case (address)
        ADDR_DATA:     data_d = wd_s;
        ADDR_OUTSET:   data_d = data_q | wd_s;
        ADDR_OUTCLEAR: data_d = data_q & ~wd_s;
        default:       data_d = data_q;
      endcase
    end else begin
      data_d = data_q;
    end
  end

  // Zero-extend DATA onto the 32-bit read bus.
  always_comb begin
    data_ext_s            = {32{1'b0}};
    data_ext_s[WIDTH-1:0] = data_q;
  end

  // Read mux, evaluated every cycle regardless of chipselect.
  always_comb begin
    readdata_d = RDATA_DEFAULT;
    case (address)
      ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLEAR: readdata_d = data_ext_s;
`ifdef NIOS_CORE_PIO_LED_BLINK_EN
      ADDR_BLINK_MASK:   readdata_d = mask_ext_s;
      ADDR_BLINK_PERIOD: readdata_d = period_ext_s;
      ADDR_STATUS:       readdata_d = {31'd0, phase_s};
`endif
      default:           readdata_d = RDATA_DEFAULT;
    endcase
  end

  // DATA and read-data registers; reset overrides any access in that cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE[WIDTH-1:0];
      readdata_q <= 32'h0000_0000;
    end else begin
      data_q     <= data_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_nios_core_pio_led_out.sv
module tb_nios_core_pio_led_out;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned PERIOD_W = 16;
  localparam int unsigned PRESCALE = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];

  // Bench-side model of the software-visible registers.
  logic [3:0] data_m;
  logic [3:0] mask_m;

  nios_core_pio_led_out #(
    .WIDTH       (WIDTH),
    .PERIOD_W    (PERIOD_W),
    .PRESCALE    (PRESCALE),
    .RESET_VALUE (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_chk(input logic [31:0] got);
    sb_t e;
    if (sb_q.size() == 0) begin
      chk_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk_eq(e.tag, got, e.exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    address = a;
    sb_push(tag, exp);
    @(negedge clk);
    sb_pop_chk(readdata);
  endtask

  task automatic out_chk(input logic [3:0] exp, input string tag);
    sb_push(tag, {28'd0, exp});
    sb_pop_chk({28'd0, out_port});
  endtask

`ifdef NIOS_CORE_PIO_LED_BLINK_EN
  function automatic logic model_phase(input int k, input int per);
    if (per == 0 || k < 0) return 1'b0;
    return ((k / (int'(PRESCALE) * per)) % 2) == 1;
  endfunction

  // Starts at the negedge right after a BLINK_PERIOD write (k=0).
  task automatic blink_run(input int n, input int per);
    logic ph;
    address = 3'd3;
    for (int k = 0; k < n; k++) begin
      ph = model_phase(k, per);
      sb_push("blink_out", {28'd0, data_m & ~(mask_m & {4{ph}})});
      sb_pop_chk({28'd0, out_port});
      if (k > 0) begin
        sb_push("status_phase", {31'd0, model_phase(k - 1, per)});
        sb_pop_chk(readdata);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    // 1: reset held 3 clocks while a DATA write is attempted
    reset_n    = 1'b0;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 3'd0;
    writedata  = 32'h0000_000F;
    repeat (3) @(negedge clk);
    out_chk(4'h0, "reset_out");
    chk_eq("reset_rdata", readdata, 32'd0);
    reset_n    = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    data_m     = 4'h0;
    mask_m     = 4'h0;
    @(negedge clk);
    out_chk(4'h0, "post_reset_out");
    chk_eq("post_reset_rdata", readdata, 32'd0);

    // 2: DATA, OUTSET, OUTCLEAR
    wr(3'd0, 32'h5);        data_m = 4'h5;
    out_chk(data_m, "data_out");
    wr(3'd4, 32'hA);        data_m = data_m | 4'hA;
    rd(3'd0, 32'hF, "outset_rd0");
    wr(3'd5, 32'h3);        data_m = data_m & ~4'h3;
    out_chk(4'hC, "outclear_out");
    rd(3'd4, 32'hC, "rd4");
    rd(3'd5, 32'hC, "rd5");
    rd(3'd6, 32'h0, "rd6");
    rd(3'd7, 32'h0, "rd7");
    wr(3'd6, 32'hF);
    rd(3'd0, 32'hC, "wr6_ignored");

`ifdef NIOS_CORE_PIO_LED_BLINK_EN
    // 3: blinking F <-> C every 8 clocks
    wr(3'd0, 32'hF);        data_m = 4'hF;
    wr(3'd1, 32'h3);        mask_m = 4'h3;
    rd(3'd1, 32'h3, "mask_rd");
    wr(3'd3, 32'h1);
    wr(3'd2, 32'h2);
    blink_run(28, 2);
    // 4: at k=28 phase is 1; rewriting PERIOD restarts with phase 0
    wr(3'd2, 32'h2);
    blink_run(12, 2);
    wr(3'd2, 32'h0);
    blink_run(20, 0);
    // 5: reset pulse mid-blink (phase=1 at k=10)
    wr(3'd2, 32'h2);
    blink_run(10, 2);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    data_m  = 4'h0;
    mask_m  = 4'h0;
    out_chk(4'h0, "midblink_reset_out");
    rd(3'd1, 32'h0, "reset_mask");
    rd(3'd2, 32'h0, "reset_period");
    rd(3'd3, 32'h0, "reset_status");
    rd(3'd0, 32'h0, "reset_data");
    wr(3'd0, 32'hF);        data_m = 4'hF;
    wr(3'd1, 32'h3);        mask_m = 4'h3;
    blink_run(20, 0);
`else
    // 6: blink registers absent
    wr(3'd1, 32'hF);
    rd(3'd1, 32'h0, "nomacro_rd1");
    wr(3'd2, 32'h5);
    rd(3'd2, 32'h0, "nomacro_rd2");
    rd(3'd3, 32'h0, "nomacro_rd3");
    wr(3'd0, 32'h9);        data_m = 4'h9;
    out_chk(4'h9, "nomacro_out");
    rd(3'd0, 32'h9, "nomacro_rd0");
    repeat (10) @(negedge clk);
    out_chk(data_m, "nomacro_steady");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
